// File: rtl/draw_pkg.sv
// Shared constants and types for the scene-drawing datapath.
package draw_pkg;

   localparam int unsigned SCREEN_W = 320;
   localparam int unsigned SCREEN_H = 240;

   localparam logic [2:0] BACK    = 3'b000;
   localparam logic [2:0] CITY    = 3'b010;
   localparam logic [2:0] MISSILE = 3'b101;
   localparam logic [2:0] DEFAULT = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      DRAW,
      DONE
   } draw_state_t;

   // Index width that stays legal for a single requester.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter
   import draw_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0] o_idx
);

   int unsigned w_j;
   logic        w_found;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      w_j      = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_j = (32'(i_ptr) + k) % N_REQ;
         if (!w_found && i_req[IDX_W'(w_j)]) begin
            w_found                 = 1'b1;
            o_onehot[IDX_W'(w_j)]   = 1'b1;
            o_idx                   = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin owner of the VGA write port; rasterises one clipped filled rectangle per grant.
module draw_arbiter
   import draw_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned X_W     = 9,
   parameter int unsigned Y_W     = 8,
   parameter int unsigned COLOR_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*X_W-1:0]     cmd_x0,
   input  logic [N_REQ*X_W-1:0]     cmd_x1,
   input  logic [N_REQ*Y_W-1:0]     cmd_y0,
   input  logic [N_REQ*Y_W-1:0]     cmd_y1,
   input  logic [N_REQ*COLOR_W-1:0] cmd_color,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic                     busy,
   output logic [X_W-1:0]           x,
   output logic [Y_W-1:0]           y,
   output logic [COLOR_W-1:0]       color,
   output logic                     plot
);

   localparam int unsigned IDX_W = idx_w(N_REQ);
   localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

   draw_state_t        r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_idx;
   logic [X_W-1:0]     r_x0;
   logic [X_W-1:0]     r_xe;
   logic [Y_W-1:0]     r_ye;

   logic [N_REQ-1:0]   w_onehot;
   logic [IDX_W-1:0]   w_idx;

   logic [X_W-1:0]     w_x0_a [N_REQ];
   logic [X_W-1:0]     w_x1_a [N_REQ];
   logic [Y_W-1:0]     w_y0_a [N_REQ];
   logic [Y_W-1:0]     w_y1_a [N_REQ];
   logic [COLOR_W-1:0] w_c_a  [N_REQ];

   logic [X_W-1:0]     w_x0, w_x1, w_xe;
   logic [Y_W-1:0]     w_y0, w_y1, w_ye;
   logic [COLOR_W-1:0] w_color;
   logic               w_empty;
   logic               w_last;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx)
   );

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_x0_a[g] = cmd_x0[g*X_W +: X_W];
      assign w_x1_a[g] = cmd_x1[g*X_W +: X_W];
      assign w_y0_a[g] = cmd_y0[g*Y_W +: Y_W];
      assign w_y1_a[g] = cmd_y1[g*Y_W +: Y_W];
      assign w_c_a[g]  = cmd_color[g*COLOR_W +: COLOR_W];
   end

   // Granted command, clipped to the visible screen.
   assign w_x0    = w_x0_a[r_idx];
   assign w_x1    = w_x1_a[r_idx];
   assign w_y0    = w_y0_a[r_idx];
   assign w_y1    = w_y1_a[r_idx];
   assign w_color = w_c_a[r_idx];
   assign w_xe    = (w_x1 > X_MAX) ? X_MAX : w_x1;
   assign w_ye    = (w_y1 > Y_MAX) ? Y_MAX : w_y1;
   assign w_empty = (w_x0 > w_xe) || (w_y0 > w_ye);
   assign w_last  = (x == r_xe) && (y == r_ye);

   // x/y outputs double as the raster cursor: they always hold the pixel on the bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_x0    <= '0;
         r_xe    <= '0;
         r_ye    <= '0;
         gnt     <= '0;
         done    <= '0;
         busy    <= 1'b0;
         x       <= '0;
         y       <= '0;
         color   <= '0;
         plot    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_state <= LATCH;
                  gnt     <= w_onehot;
                  r_idx   <= w_idx;
                  busy    <= 1'b1;
               end
            end
            LATCH: begin
               r_x0  <= w_x0;
               r_xe  <= w_xe;
               r_ye  <= w_ye;
               color <= w_color;
               x     <= w_x0;
               y     <= w_y0;
               if (w_empty) begin
                  r_state <= DONE;
                  gnt     <= '0;
                  done    <= gnt;
               end else begin
                  r_state <= DRAW;
                  plot    <= 1'b1;
               end
            end
            DRAW: begin
               if (w_last) begin
                  r_state <= DONE;
                  plot    <= 1'b0;
                  gnt     <= '0;
                  done    <= gnt;
               end else if (x == r_xe) begin
                  x <= r_x0;
                  y <= y + 1'b1;
               end else begin
                  x <= x + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               done    <= '0;
               busy    <= 1'b0;
               r_ptr   <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: a rectangle/round-robin model predicts every pixel and done pulse.
module tb_draw_arbiter;
   import draw_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;
   localparam int unsigned CW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*XW-1:0] cmd_x0 = '0, cmd_x1 = '0;
   logic [N*YW-1:0] cmd_y0 = '0, cmd_y1 = '0;
   logic [N*CW-1:0] cmd_color = '0;
   logic [N-1:0]    gnt, done;
   logic            busy, plot;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic [CW-1:0]   color;

   draw_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) dut (
      .clk(clk), .rst(rst), .req(req),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_color(cmd_color),
      .gnt(gnt), .done(done), .busy(busy),
      .x(x), .y(y), .color(color), .plot(plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int idx;
      int px;
      int py;
      int pc;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;
   int   ptr_m    = 0;
   int   bx0[N], bx1[N], by0[N], by1[N], bc[N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic pack_cmds();
      for (int i = 0; i < int'(N); i++) begin
         cmd_x0[i*XW +: XW]    = XW'(bx0[i]);
         cmd_x1[i*XW +: XW]    = XW'(bx1[i]);
         cmd_y0[i*YW +: YW]    = YW'(by0[i]);
         cmd_y1[i*YW +: YW]    = YW'(by1[i]);
         cmd_color[i*CW +: CW] = CW'(bc[i]);
      end
   endtask

   // Predict service order and all pixels for requests held together from IDLE cycle a.
   task automatic model_batch(input logic [N-1:0] set, input int a_in);
      logic [N-1:0] pend;
      int a;
      pend = set;
      a    = a_in;
      while (pend != '0) begin
         int w, xe, ye, p;
         exp_t e;
         w = -1;
         for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (ptr_m + k) % int'(N);
            if (w < 0 && pend[j]) w = j;
         end
         xe = (bx1[w] > int'(SCREEN_W) - 1) ? int'(SCREEN_W) - 1 : bx1[w];
         ye = (by1[w] > int'(SCREEN_H) - 1) ? int'(SCREEN_H) - 1 : by1[w];
         p  = 0;
         if (bx0[w] <= xe && by0[w] <= ye) begin
            for (int yy = by0[w]; yy <= ye; yy++)
               for (int xx = bx0[w]; xx <= xe; xx++) begin
                  e = '{1'b0, w, xx, yy, bc[w], 0};
                  sbq.push_back(e);
                  p++;
               end
         end
         e = '{1'b1, w, 0, 0, 0, a + 2 + p};
         sbq.push_back(e);
         a        = a + 3 + p;
         ptr_m    = (w + 1) % int'(N);
         pend[w]  = 1'b0;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the idle negedge after the last done.
   task automatic run_batch(input logic [N-1:0] set);
      logic [N-1:0] served;
      int budget;
      served = '0;
      budget = 0;
      pack_cmds();
      model_batch(set, cyc);
      req = set;
      while (served != set && budget < 90000) begin
         @(negedge clk);
         budget++;
         if (done != '0) begin
            served = served | done;
            req    = req & ~done;
         end else if (plot) begin
            for (int g = 0; g < int'(N); g++) if (gnt[g]) begin
               if ($urandom_range(0, 3) == 0) cmd_color[g*CW +: CW] = CW'($urandom);
               if ($urandom_range(0, 3) == 0) cmd_x1[g*XW +: XW]    = XW'($urandom);
               if ($urandom_range(0, 15) == 0) req[g] = 1'b0;
            end
         end
      end
      if (served != set) begin
         chk("batch_timeout", int'(served), int'(set));
         req = '0;
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (plot) begin
            if (sbq.size() == 0 || sbq[0].is_done) chk("unexpected_plot", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("pix_x", int'(x), e.px);
               chk("pix_y", int'(y), e.py);
               chk("pix_color", int'(color), e.pc);
               chk("pix_gnt", int'(gnt), 1 << e.idx);
            end
         end
         if (done != '0) begin
            if (sbq.size() == 0 || !sbq[0].is_done) chk("unexpected_done", int'(done), 0);
            else begin
               e = sbq.pop_front();
               chk("done_vec", int'(done), 1 << e.idx);
               chk("done_cycle", cyc, e.cyc);
               chk("done_gnt", int'(gnt), 0);
               chk("done_plot", int'(plot), 0);
            end
         end
      end
   end

   task automatic set_cmd(input int i, input int ax0, input int ax1, input int ay0,
                          input int ay1, input int ac);
      bx0[i] = ax0; bx1[i] = ax1; by0[i] = ay0; by1[i] = ay1; bc[i] = ac;
   endtask

   initial begin
      int n;
      logic [N-1:0] set;
      for (int i = 0; i < int'(N); i++) set_cmd(i, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_plot", int'(plot), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_color", int'(color), 0);
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      set_cmd(0, 0, 319, 0, 239, int'(BACK));
      run_batch(4'b0001);

      set_cmd(1, 10, 10, 10, 10, int'(CITY));
      set_cmd(2, 20, 20, 20, 20, int'(MISSILE));
      run_batch(4'b0110);
      set_cmd(0, 1, 1, 2, 2, int'(CITY));
      set_cmd(3, 3, 3, 4, 4, int'(MISSILE));
      run_batch(4'b1001);

      set_cmd(2, 300, 400, 230, 250, int'(DEFAULT));
      run_batch(4'b0100);
      set_cmd(1, 50, 40, 5, 6, int'(CITY));
      run_batch(4'b0010);

      repeat (40) begin
         set = N'($urandom_range(1, 15));
         for (int i = 0; i < int'(N); i++) begin
            bx0[i] = int'($urandom_range(0, 330));
            bx1[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, bx0[i]))
                                                 : bx0[i] + int'($urandom_range(0, 7));
            by0[i] = int'($urandom_range(0, 245));
            by1[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, by0[i]))
                                                 : by0[i] + int'($urandom_range(0, 5));
            bc[i]  = int'($urandom_range(0, 7));
         end
         run_batch(set);
      end
      chk("sb_empty", sbq.size(), 0);

      // Reset in the middle of a 16x10 rectangle.
      mon_en = 1'b0;
      set_cmd(1, 5, 20, 5, 14, int'(DEFAULT));
      pack_cmds();
      req = 4'b0010;
      n = 0;
      for (int b = 0; b < 200 && n < 37; b++) begin
         @(negedge clk);
         if (plot) n++;
      end
      chk("rst_mid_reached", n, 37);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_plot", int'(plot), 0);
      chk("rst_mid_gnt", int'(gnt), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_x", int'(x), 0);
      req = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      sbq.delete();
      ptr_m  = 0;
      mon_en = 1'b1;
      set_cmd(0, 7, 8, 7, 7, int'(CITY));
      set_cmd(3, 9, 9, 9, 10, int'(MISSILE));
      run_batch(4'b1001);
      chk("sb_empty_end", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1500000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single VGA adapter write port (x, y, color, plot) between several scene-drawing requesters: background fill, ground, launcher, cities and, later, missiles. Each requester posts one filled-rectangle command. The block grants requesters round-robin and rasterises the granted rectangle at one pixel per clock. It sits between the game-sequencing FSMs and vga_adapter, replacing per-FSM hard-coded count_x/count_y loops.

## Interface
Parameters:
- N_REQ, 4: number of requesters
- X_W, 9: x coordinate width
- Y_W, 8: y coordinate width
- COLOR_W, 3: color width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester draw request (level)
- cmd_x0, cmd_x1  in  N_REQ*X_W  packed rectangle x bounds, inclusive; requester i at slice i
- cmd_y0, cmd_y1  in  N_REQ*Y_W  packed rectangle y bounds, inclusive
- cmd_color  in  N_REQ*COLOR_W  packed fill color
- gnt  out  N_REQ  one-hot grant; high while requester's command is being drawn
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  state is not IDLE
- x  out  X_W  pixel x to vga_adapter
- y  out  Y_W  pixel y to vga_adapter
- color  out  COLOR_W  pixel color to vga_adapter
- plot  out  1  write strobe; pixel valid this cycle

## Operation
- FSM states: IDLE, LATCH, DRAW, DONE.
- IDLE: if req != 0, go to LATCH and grant the round-robin winner.
  - Round-robin search starts at pointer ptr and wraps.
  - ptr resets to 0.
- LATCH:
  - gnt[i] asserted and held through DRAW.
  - Command slice i registered: x0, y0, color.
  - Clipped bounds: xe = min(x1, 319), ye = min(y1, 239).
  - Cursor loaded with (x0, y0).
  - If x0 > xe or y0 > ye, the rectangle is empty: go to DONE with no plot. Otherwise go to DRAW.
- DRAW:
  - Drive plot=1, x=cursor x, y=cursor y, color=latched color. All outputs are registered.
  - Raster order is row-major. Cursor x increments; when cursor x == xe, x returns to x0 and y increments.
  - The pixel at (xe, ye) is the last one; go to DONE.
- DONE:
  - plot=0, gnt=0, done[i]=1 for one cycle.
  - ptr = (i+1) mod N_REQ.
  - Go to IDLE.
- Command inputs are sampled only in LATCH; later changes are ignored.
- Deasserting req mid-draw does not abort; the rectangle completes and done still pulses.
- Requester must drop req on the cycle after done, or it will be re-served when next in round-robin order.
- Comparisons are unsigned. The cursor uses X_W/Y_W registers, with no wrap inside a valid clipped rectangle.

## Timing
- Reset values: state IDLE, gnt=0, done=0, busy=0, plot=0, x=0, y=0, color=0, ptr=0.
- For a req seen in IDLE at cycle t with P=(xe-x0+1)*(ye-y0+1) pixels:
  - LATCH at t+1.
  - plot high for cycles t+2 through t+1+P, one pixel per cycle, no gaps.
  - done at t+2+P.
  - IDLE at t+3+P; a new grant can be sampled there.
- Empty rectangle: done at t+2.
- Full screen (320x240): P=76800, done at t+76802.
- Simultaneous requests: exactly one is granted; others wait with req held.
- Reset asserted mid-operation forces all outputs to reset values immediately. Partial frame contents are not restored.

## Structure
- Shared package draw_pkg:
  - SCREEN_W=320, SCREEN_H=240.
  - Color constants: BACK=3'b000, CITY=3'b010, MISSILE=3'b101, DEFAULT=3'b111.
  - State enum: IDLE, LATCH, DRAW, DONE.
- Sub-module rr_arbiter: inputs req and ptr; outputs one-hot winner and winner index. Combinational. Reused later for missile-launch arbitration.
- Rasteriser cursor and FSM live in draw_arbiter.

## Test plan
- Single req[0]: (0,0)-(319,239), color 000 → 76800 consecutive plot cycles starting t+2, last pixel (319,239), done[0] at t+76802.
- req[1] and req[2] asserted together, 1x1 rects at (10,10) and (20,20):
  - req[1] is served first, one plot each; req[2] follows.
  - Then with ptr=3, req[0] and req[3] both asserted → req[3] is served first.
- Clipping: (300,230)-(400,250) → plots x 300..319, y 230..239 (200 pixels); no x>319 or y>239 ever appears.
- Empty rect: x0=50, x1=40 → no plot; done at t+2; gnt high only in LATCH.
- Command change mid-draw: alter cmd_color and cmd_x1 during DRAW → output still uses latched values; req dropped mid-draw still yields done.
- Reset mid-DRAW of a 16x10 rect at pixel 37 → plot=0, gnt=0, busy=0 in the reset cycle; after release, IDLE with ptr=0.
